// File: rtl/vga_sync.sv
// 640x480 @ 60 Hz VGA timing generator: divides clk down to the pixel rate, walks
// the raster, and registers coordinates, sync, blanking and tick pulses together.
module vga_sync #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_tick
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [9:0]    X_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0]    Y_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0]    X_VIS    = 10'(H_VIS);
  localparam logic [9:0]    Y_VIS    = 10'(V_VIS);
  localparam logic [9:0]    HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0]    HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]    VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic [9:0]    x_next;
  logic [9:0]    y_next;
  logic          adv;
  logic          frame_wrap;

  // NOTE: every signal assigned in this block gets a default first, so no latches.
  always_comb begin
    adv        = (div_cnt == DIV_LAST);
    div_next   = adv ? '0 : div_cnt + DW'(1);
    x_next     = x;
    y_next     = y;
    frame_wrap = 1'b0;
    if (adv) begin
      if (x == X_LAST) begin
        x_next     = '0;
        y_next     = (y == Y_LAST) ? '0 : y + 10'd1;
        frame_wrap = (y == Y_LAST);
      end else begin
        x_next = x + 10'd1;
      end
    end
  end

  // Flags are decoded from next-state x/y so they land on the same edge as x/y.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      x          <= '0;
      y          <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b1;
      p_tick     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= div_next;
      x          <= x_next;
      y          <= y_next;
      hsync      <= !((x_next >= HS_START) && (x_next < HS_END));
      vsync      <= !((y_next >= VS_START) && (y_next < VS_END));
      video_on   <= (x_next < X_VIS) && (y_next < Y_VIS);
      p_tick     <= (div_next == DIV_LAST);
      frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a full-size instance for line-level timing and a shrunken
// raster instance so whole frames, wraps and random resets fit in a short run.
module tb_vga_sync;

  // Shrunken raster: 24 pixels x 13 lines, 4 clks per pixel, 1248 clks per frame.
  localparam int S_DIV = 4, S_HV = 16, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VV = 6, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HTOT  = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VTOT  = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HTOT * S_VTOT * S_DIV;
  localparam int F_LINE  = 800 * 4;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic       frame_tick;
  } obs_t;

  localparam obs_t RESET_OBS = '{x: 10'd0, y: 10'd0, hsync: 1'b1, vsync: 1'b1,
                                 video_on: 1'b1, p_tick: 1'b0, frame_tick: 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_f = 1'b0, reset_s = 1'b0;
  logic [9:0] x_f, y_f, x_s, y_s;
  logic       hsync_f, vsync_f, video_on_f, p_tick_f, frame_tick_f;
  logic       hsync_s, vsync_s, video_on_s, p_tick_s, frame_tick_s;
  obs_t       obs_f, obs_s;

  vga_sync dut_f (
    .clk(clk), .reset(reset_f), .x(x_f), .y(y_f), .hsync(hsync_f), .vsync(vsync_f),
    .video_on(video_on_f), .p_tick(p_tick_f), .frame_tick(frame_tick_f)
  );

  vga_sync #(
    .DIV(S_DIV), .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_s (
    .clk(clk), .reset(reset_s), .x(x_s), .y(y_s), .hsync(hsync_s), .vsync(vsync_s),
    .video_on(video_on_s), .p_tick(p_tick_s), .frame_tick(frame_tick_s)
  );

  assign obs_f = {x_f, y_f, hsync_f, vsync_f, video_on_f, p_tick_f, frame_tick_f};
  assign obs_s = {x_s, y_s, hsync_s, vsync_s, video_on_s, p_tick_s, frame_tick_s};

  int checks = 0;
  int errors = 0;
  int t_f = 0;  // clk edges since the last reset edge, per instance
  int t_s = 0;

  // Expected outputs t edges after reset, straight from raster arithmetic.
  function automatic obs_t model(input int t, input int dv, input int hv, input int hf,
                                 input int hs, input int hb, input int vv, input int vf,
                                 input int vs, input int vb);
    obs_t m;
    int htot = hv + hf + hs + hb;
    int vtot = vv + vf + vs + vb;
    int pix  = t / dv;
    int xx   = pix % htot;
    int yy   = (pix / htot) % vtot;
    m.x          = 10'(xx);
    m.y          = 10'(yy);
    m.hsync      = !(xx >= hv + hf && xx < hv + hf + hs);
    m.vsync      = !(yy >= vv + vf && yy < vv + vf + vs);
    m.video_on   = (xx < hv) && (yy < vv);
    m.p_tick     = (t % dv) == dv - 1;
    m.frame_tick = (t % dv == 0) && (pix > 0) && (pix % (htot * vtot) == 0);
    return m;
  endfunction

  function automatic obs_t model_f(input int t);
    return model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic obs_t model_s(input int t);
    return model(t, S_DIV, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
  endfunction

  task automatic step();
    @(posedge clk);
    t_f = reset_f ? 0 : t_f + 1;
    t_s = reset_s ? 0 : t_s + 1;
    #1;
  endtask

  task automatic test_reset();
    int first_tick = -1;
    reset_f = 1'b1;
    reset_s = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (obs_f !== RESET_OBS) begin
        errors++;
        $display("FAIL reset_state_full got=%h want=%h", obs_f, RESET_OBS);
      end
      checks++;
      if (obs_s !== RESET_OBS) begin
        errors++;
        $display("FAIL reset_state_small got=%h want=%h", obs_s, RESET_OBS);
      end
    end
    reset_f = 1'b0;
    reset_s = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (obs_f !== model_f(t_f)) begin
        errors++;
        $display("FAIL release_seq t=%0d got=%h want=%h", t_f, obs_f, model_f(t_f));
      end
      if (p_tick_f && first_tick < 0) first_tick = k;
      if (k == 4) begin
        checks++;
        if (x_f !== 10'd1) begin
          errors++;
          $display("FAIL first_advance got x=%0d want x=1", x_f);
        end
      end
    end
    // div_cnt goes 0,1,2,3 on successive edges; the pulse coincides with 3
    checks++;
    if (first_tick != 3) begin
      errors++;
      $display("FAIL first_p_tick got edge=%0d want edge=3", first_tick);
    end
  endtask

  task automatic test_line();
    int hs_low = 0;
    int fall_x = -1;
    logic prev_von = video_on_f;
    logic [9:0] prev_x = x_f;
    for (int k = 0; k < F_LINE; k++) begin
      step();
      checks++;
      if (obs_f !== model_f(t_f)) begin
        errors++;
        $display("FAIL line_seq t=%0d got=%h want=%h", t_f, obs_f, model_f(t_f));
      end
      if (!hsync_f) hs_low++;
      if (prev_von && !video_on_f && fall_x < 0) fall_x = x_f;
      if (prev_x == 10'd799 && x_f == 10'd0) begin
        checks++;
        if (y_f !== 10'd1) begin
          errors++;
          $display("FAIL line_wrap_y got y=%0d want y=1", y_f);
        end
      end
      prev_von = video_on_f;
      prev_x   = x_f;
    end
    checks++;
    if (hs_low != 96 * 4) begin
      errors++;
      $display("FAIL hsync_width got=%0d clks want=384 clks", hs_low);
    end
    checks++;
    if (fall_x != 640) begin
      errors++;
      $display("FAIL video_on_fall got x=%0d want x=640", fall_x);
    end
  endtask

  task automatic test_reset_mid_line();
    int n = 0;
    logic [9:0] prev_x;
    while (x_f != 10'd700 && n < 2 * F_LINE) begin
      step();
      n++;
    end
    checks++;
    if (x_f != 10'd700) begin
      errors++;
      $display("FAIL reach_x700 got x=%0d want x=700", x_f);
    end
    reset_f = 1'b1;
    step();
    reset_f = 1'b0;
    checks++;
    if (obs_f !== RESET_OBS) begin
      errors++;
      $display("FAIL mid_line_reset got=%h want=%h", obs_f, RESET_OBS);
    end
    n = 0;
    prev_x = x_f;
    while (!(prev_x == 10'd799 && x_f == 10'd0) && n < F_LINE + 100) begin
      prev_x = x_f;
      step();
      n++;
      checks++;
      if (obs_f !== model_f(t_f)) begin
        errors++;
        $display("FAIL post_reset_seq t=%0d got=%h want=%h", t_f, obs_f, model_f(t_f));
      end
    end
    checks++;
    if (n != F_LINE) begin
      errors++;
      $display("FAIL line_period got=%0d clks want=%0d clks", n, F_LINE);
    end
  endtask

  task automatic test_frame();
    int pt = 0, ft = 0, vs_low = 0, last_ft = -1;
    logic prev_ft = frame_tick_s;
    logic [9:0] prev_x = x_s, prev_y = y_s;
    for (int k = 0; k < 2 * S_FRAME; k++) begin
      step();
      checks++;
      if (obs_s !== model_s(t_s)) begin
        errors++;
        $display("FAIL frame_seq t=%0d got=%h want=%h", t_s, obs_s, model_s(t_s));
      end
      checks++;
      if (video_on_s !== (x_s < S_HV && y_s < S_VV)) begin
        errors++;
        $display("FAIL video_on_rule x=%0d y=%0d got=%b", x_s, y_s, video_on_s);
      end
      if (p_tick_s) pt++;
      if (!vsync_s) vs_low++;
      if (frame_tick_s) begin
        ft++;
        checks++;
        if ({x_s, y_s, vsync_s, video_on_s, prev_ft} !== {20'd0, 1'b1, 1'b1, 1'b0} ||
            prev_x != 10'(S_HTOT - 1) || prev_y != 10'(S_VTOT - 1)) begin
          errors++;
          $display("FAIL wrap_corner got x=%0d y=%0d vs=%b von=%b prev=(%0d,%0d,ft=%b) want (0,0,1,1) from (%0d,%0d,ft=0)",
                   x_s, y_s, vsync_s, video_on_s, prev_x, prev_y, prev_ft, S_HTOT - 1, S_VTOT - 1);
        end
        if (last_ft >= 0) begin
          checks++;
          if (k - last_ft != S_FRAME) begin
            errors++;
            $display("FAIL frame_period got=%0d clks want=%0d clks", k - last_ft, S_FRAME);
          end
        end
        last_ft = k;
      end
      prev_ft = frame_tick_s;
      prev_x  = x_s;
      prev_y  = y_s;
    end
    checks++;
    if (pt != 2 * S_FRAME / S_DIV) begin
      errors++;
      $display("FAIL p_tick_count got=%0d want=%0d", pt, 2 * S_FRAME / S_DIV);
    end
    checks++;
    if (ft != 2) begin
      errors++;
      $display("FAIL frame_tick_count got=%0d want=2", ft);
    end
    checks++;
    if (vs_low != 2 * S_VS * S_HTOT * S_DIV) begin
      errors++;
      $display("FAIL vsync_width got=%0d clks want=%0d clks", vs_low, 2 * S_VS * S_HTOT * S_DIV);
    end
  endtask

  task automatic test_reset_in_sync();
    int n = 0;
    logic [9:0] prev_x;
    while (!(hsync_s == 1'b0 && vsync_s == 1'b0) && n < 2 * S_FRAME) begin
      step();
      n++;
    end
    checks++;
    if (hsync_s !== 1'b0 || vsync_s !== 1'b0) begin
      errors++;
      $display("FAIL reach_sync got hs=%b vs=%b want hs=0 vs=0", hsync_s, vsync_s);
    end
    reset_s = 1'b1;
    step();
    reset_s = 1'b0;
    checks++;
    if (obs_s !== RESET_OBS) begin
      errors++;
      $display("FAIL sync_reset got=%h want=%h", obs_s, RESET_OBS);
    end
    n = 0;
    prev_x = x_s;
    while (!(prev_x == 10'(S_HTOT - 1) && x_s == 10'd0) && n < 2 * S_HTOT * S_DIV) begin
      prev_x = x_s;
      step();
      n++;
    end
    checks++;
    if (n != S_HTOT * S_DIV) begin
      errors++;
      $display("FAIL sync_reset_line_period got=%0d clks want=%0d clks", n, S_HTOT * S_DIV);
    end
  endtask

  task automatic test_random_reset();
    for (int r = 0; r < 20; r++) begin
      int run = $urandom_range(300, 1);
      int hold = $urandom_range(3, 1);
      repeat (run) begin
        step();
        checks++;
        if (obs_s !== model_s(t_s)) begin
          errors++;
          $display("FAIL random_run t=%0d got=%h want=%h", t_s, obs_s, model_s(t_s));
        end
      end
      reset_s = 1'b1;
      repeat (hold) begin
        step();
        checks++;
        if (obs_s !== RESET_OBS) begin
          errors++;
          $display("FAIL random_reset got=%h want=%h", obs_s, RESET_OBS);
        end
      end
      reset_s = 1'b0;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_line();
    test_reset_mid_line();
    test_frame();
    test_reset_in_sync();
    test_random_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
